// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states and default clocking.
// Imported by the receiver and the transmitter.
package uart_pkg;

    localparam int CLK_HZ_DEF = 50_000_000;
    localparam int BAUD_DEF   = 9600;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } rx_state_e;

    // Clocks per serial bit, truncated.
    function automatic int baud_div(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Receiver-side bundle: serial line in, byte/flag handshake out.
// master = the receiver, slave = the consuming stage.
interface uart_rx_if;

    logic       rxd;
    logic [7:0] rx_data;
    logic       rx_flag;
    logic       rx_ack;
    logic       rx_overrun;
    logic       rx_frame_err;

    modport master (
        input  rxd,
        input  rx_ack,
        output rx_data,
        output rx_flag,
        output rx_overrun,
        output rx_frame_err
    );

    modport slave (
        output rxd,
        output rx_ack,
        input  rx_data,
        input  rx_flag,
        input  rx_overrun,
        input  rx_frame_err
    );

endinterface

// File: rtl/uart_rx_sync_2ff.sv
// Two-flop synchronizer for one asynchronous bit.
// RST_VAL is the value both flops hold while in reset.
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q
);

    logic [1:0] r_ff;

    // Shift the async input through two flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ff <= {RST_VAL, RST_VAL};
        end else begin
            r_ff <= {r_ff[0], i_d};
        end
    end

    assign o_q = r_ff[1];

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling, one-byte holding register,
// sticky overrun and a frame-error pulse.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_HZ = CLK_HZ_DEF,
    parameter int BAUD   = BAUD_DEF
) (
    input logic      eclk,
    input logic      ereset_n,
    uart_rx_if.master bus
);

    localparam int DIV  = baud_div(CLK_HZ, BAUD);
    localparam int HALF = DIV / 2;
    localparam int CW   = $clog2(DIV);

    localparam logic [CW-1:0] TICK_HALF = CW'(HALF - 1);
    localparam logic [CW-1:0] TICK_FULL = CW'(DIV - 1);
    localparam logic [CW-1:0] TICK_ONE  = CW'(1);

    logic          w_rxs;
    logic          w_tick0;
    rx_state_e     r_state;
    logic [CW-1:0] r_tick;
    logic [2:0]    r_bit;
    logic [7:0]    r_shift;
    logic          r_dlv;
    logic          r_ferr;
    logic [7:0]    r_data;
    logic          r_flag;
    logic          r_ovr;

    sync_2ff #(
        .RST_VAL (1'b1)
    ) u_sync (
        .clk   (eclk),
        .rst_n (ereset_n),
        .i_d   (bus.rxd),
        .o_q   (w_rxs)
    );

    assign w_tick0 = (r_tick == '0);

    // Frame FSM: one sample per bit, counter reloaded on each sample.
    always_ff @(posedge eclk or negedge ereset_n) begin
        if (!ereset_n) begin
            r_state <= ST_IDLE;
            r_tick  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_dlv   <= 1'b0;
            r_ferr  <= 1'b0;
        end else begin
            r_dlv  <= 1'b0;
            r_ferr <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    if (!w_rxs) begin
                        r_state <= ST_START;
                        r_bit   <= '0;
                        r_tick  <= TICK_HALF;
                    end
                end
                ST_START: begin
                    if (!w_tick0) begin
                        r_tick <= r_tick - TICK_ONE;
                    end else if (!w_rxs) begin
                        r_state <= ST_DATA;
                        r_tick  <= TICK_FULL;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_DATA: begin
                    if (!w_tick0) begin
                        r_tick <= r_tick - TICK_ONE;
                    end else begin
                        r_shift <= {w_rxs, r_shift[7:1]};
                        r_tick  <= TICK_FULL;
                        r_bit   <= r_bit + 3'd1;
                        if (r_bit == 3'd7) begin
                            r_state <= ST_STOP;
                        end
                    end
                end
                ST_STOP: begin
                    if (!w_tick0) begin
                        r_tick <= r_tick - TICK_ONE;
                    end else if (w_rxs) begin
                        r_dlv   <= 1'b1;
                        r_state <= ST_IDLE;
                    end else begin
                        r_ferr  <= 1'b1;
                        r_state <= ST_BREAK;
                    end
                end
                ST_BREAK: begin
                    if (w_rxs) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Holding register; a new byte always wins over a pending one.
    always_ff @(posedge eclk or negedge ereset_n) begin
        if (!ereset_n) begin
            r_data <= 8'h00;
            r_flag <= 1'b0;
            r_ovr  <= 1'b0;
        end else if (r_dlv) begin
            r_data <= r_shift;
            r_flag <= 1'b1;
            r_ovr  <= (bus.rx_ack && r_flag) ? 1'b0 : (r_ovr | r_flag);
        end else if (bus.rx_ack && r_flag) begin
            r_flag <= 1'b0;
            r_ovr  <= 1'b0;
        end
    end

    assign bus.rx_data      = r_data;
    assign bus.rx_flag      = r_flag;
    assign bus.rx_overrun   = r_ovr;
    assign bus.rx_frame_err = r_ferr;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx at DIV=16: frames driven on negedges,
// expected bytes and delivery cycles checked through a queue.
module tb_uart_rx;

    typedef struct {
        logic [7:0] data;
        int         cyc;
    } exp_t;

    logic eclk;
    logic ereset_n;
    int   cyc;
    int   n_chk;
    int   n_pass;
    int   n_unexp;
    int   fe_cnt;
    int   fe_len;
    int   fe_max;
    exp_t exp_q[$];
    logic       m_prev_flag;
    logic [7:0] m_prev_data;

    uart_rx_if bus();

    uart_rx #(
        .CLK_HZ (160),
        .BAUD   (10)
    ) dut (
        .eclk     (eclk),
        .ereset_n (ereset_n),
        .bus      (bus)
    );

    initial eclk = 1'b0;
    always #5 eclk = ~eclk;

    // Posedge count used to time deliveries.
    always @(posedge eclk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", tag, got, exp);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge eclk);
    endtask

    // Drives n clocks of a frame starting at a negedge.
    task automatic send_frame(input logic [7:0] b, input logic stop_v,
                              input logic ack_dlv, input int n);
        logic [9:0] bits;
        bits = {stop_v, b, 1'b0};
        for (int k = 0; k < n; k++) begin
            bus.rxd    = bits[k / 16];
            bus.rx_ack = ack_dlv && (k == 155);
            @(negedge eclk);
        end
        bus.rx_ack = 1'b0;
    endtask

    task automatic push_exp(input logic [7:0] b);
        exp_t e;
        e.data = b;
        e.cyc  = cyc + 156;
        exp_q.push_back(e);
    endtask

    task automatic ack_pulse;
        bus.rx_ack = 1'b1;
        @(negedge eclk);
        bus.rx_ack = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_data"}, {24'h0, bus.rx_data}, 32'h00);
        chk({tag, "_flag"}, {31'h0, bus.rx_flag}, 32'h0);
        chk({tag, "_ovr"}, {31'h0, bus.rx_overrun}, 32'h0);
        chk({tag, "_ferr"}, {31'h0, bus.rx_frame_err}, 32'h0);
    endtask

    // Delivery monitor: new byte seen as flag rise or data change.
    always @(posedge eclk) begin
        exp_t e;
        #1;
        if (ereset_n && bus.rx_flag &&
            (!m_prev_flag || bus.rx_data != m_prev_data)) begin
            if (exp_q.size() == 0) begin
                n_unexp++;
            end else begin
                e = exp_q.pop_front();
                chk("rx_data", {24'h0, bus.rx_data}, {24'h0, e.data});
                chk("dlv_cyc", cyc, e.cyc);
            end
        end
        m_prev_flag = bus.rx_flag;
        m_prev_data = bus.rx_data;
    end

    // Frame-error pulse counter and width tracker.
    always @(posedge eclk) begin
        #1;
        if (ereset_n && bus.rx_frame_err) begin
            fe_len++;
            if (fe_len == 1) fe_cnt++;
            if (fe_len > fe_max) fe_max = fe_len;
        end else begin
            fe_len = 0;
        end
    end

    initial begin
        cyc = 0; n_chk = 0; n_pass = 0; n_unexp = 0;
        fe_cnt = 0; fe_len = 0; fe_max = 0;
        m_prev_flag = 1'b0; m_prev_data = 8'h00;
        ereset_n = 1'b0;
        bus.rxd = 1'b1;
        bus.rx_ack = 1'b0;
        idle(4);
        chk_reset_vals("rst");
        ereset_n = 1'b1;
        idle(10);

        // Single frame 0x41, then ack.
        push_exp(8'h41);
        send_frame(8'h41, 1'b1, 1'b0, 160);
        chk("f41_flag", {31'h0, bus.rx_flag}, 32'h1);
        chk("f41_data", {24'h0, bus.rx_data}, 32'h41);
        chk("f41_ovr", {31'h0, bus.rx_overrun}, 32'h0);
        ack_pulse();
        chk("f41_ack_flag", {31'h0, bus.rx_flag}, 32'h0);
        ack_pulse();
        chk("idle_ack_flag", {31'h0, bus.rx_flag}, 32'h0);
        chk("idle_ack_data", {24'h0, bus.rx_data}, 32'h41);
        idle(5);

        // 5-clock glitch on idle line.
        bus.rxd = 1'b0;
        idle(5);
        bus.rxd = 1'b1;
        idle(40);
        chk("glitch_flag", {31'h0, bus.rx_flag}, 32'h0);
        chk("glitch_ferr", fe_cnt, 0);

        // 0x55 with low stop bit, line held low in break.
        send_frame(8'h55, 1'b0, 1'b0, 160);
        idle(200);
        chk("brk_flag", {31'h0, bus.rx_flag}, 32'h0);
        bus.rxd = 1'b1;
        idle(40);
        chk("brk_ferr_cnt", fe_cnt, 1);
        chk("brk_ferr_width", fe_max, 1);
        chk("brk_data", {24'h0, bus.rx_data}, 32'h41);

        // Overrun: 0x12 then 0x34 without ack.
        push_exp(8'h12);
        send_frame(8'h12, 1'b1, 1'b0, 160);
        push_exp(8'h34);
        send_frame(8'h34, 1'b1, 1'b0, 160);
        chk("ovr_flag", {31'h0, bus.rx_flag}, 32'h1);
        chk("ovr_data", {24'h0, bus.rx_data}, 32'h34);
        chk("ovr_set", {31'h0, bus.rx_overrun}, 32'h1);
        ack_pulse();
        chk("ovr_ack_flag", {31'h0, bus.rx_flag}, 32'h0);
        chk("ovr_ack_ovr", {31'h0, bus.rx_overrun}, 32'h0);
        idle(5);

        // Ack coincident with delivery of the second byte.
        push_exp(8'h12);
        send_frame(8'h12, 1'b1, 1'b0, 160);
        push_exp(8'h34);
        send_frame(8'h34, 1'b1, 1'b1, 160);
        chk("coin_flag", {31'h0, bus.rx_flag}, 32'h1);
        chk("coin_data", {24'h0, bus.rx_data}, 32'h34);
        chk("coin_ovr", {31'h0, bus.rx_overrun}, 32'h0);
        ack_pulse();
        chk("coin_ack_flag", {31'h0, bus.rx_flag}, 32'h0);
        idle(5);

        // Reset during data bit 4 of 0x7F, then a clean 0x0D.
        send_frame(8'h7F, 1'b1, 1'b0, 88);
        ereset_n = 1'b0;
        bus.rxd = 1'b1;
        idle(5);
        chk_reset_vals("mid_rst");
        ereset_n = 1'b1;
        idle(200);
        chk_reset_vals("post_rst");
        push_exp(8'h0D);
        send_frame(8'h0D, 1'b1, 1'b0, 160);
        chk("f0d_flag", {31'h0, bus.rx_flag}, 32'h1);
        chk("f0d_data", {24'h0, bus.rx_data}, 32'h0D);
        chk("f0d_ovr", {31'h0, bus.rx_overrun}, 32'h0);
        idle(20);

        chk("sb_left", exp_q.size(), 0);
        chk("unexp_dlv", n_unexp, 0);
        chk("ferr_total", fe_cnt, 1);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter CLK_HZ, default 50000000, eclk frequency in Hz.
REQ-002 Parameter BAUD, default 9600, serial bit rate; DIV = CLK_HZ/BAUD (integer, truncated), HALF = DIV/2; DIV SHALL be >= 4.
REQ-003 eclk  input  1  single clock; all state on rising edge.
REQ-004 ereset_n  input  1  reset, asynchronous, active-low.
REQ-005 rxd  input  1  asynchronous serial line, idle high, 8N1, LSB first.
REQ-006 rx_data  output  8  last received byte.
REQ-007 rx_flag  output  1  byte available, level, held until acknowledged.
REQ-008 rx_ack  input  1  one-cycle consume strobe from the keyboard stage.
REQ-009 rx_overrun  output  1  sticky: byte delivered while rx_flag already set.
REQ-010 rx_frame_err  output  1  one-cycle pulse: stop bit sampled low.

Function
REQ-011 rxd SHALL pass through a 2-flop synchronizer; all decisions use the synchronized value (rxs).
REQ-012 FSM states: IDLE, START, DATA, STOP, BREAK.
REQ-013 IDLE: rxs==0 -> START, bit counter cleared, tick counter loaded.
REQ-014 START: after HALF cycles sample rxs; 0 -> DATA; 1 -> IDLE (glitch rejected, nothing reported).
REQ-015 DATA: sample every DIV cycles from the start-bit sample; shift LSB first; after 8th sample -> STOP.
REQ-016 STOP: sample DIV cycles after the 8th data sample; 1 -> deliver, IDLE; 0 -> rx_frame_err pulse, no delivery, BREAK.
REQ-017 BREAK: remain until rxs==1, then IDLE.
REQ-018 Delivery: rx_data updated and rx_flag set on the cycle after the stop sample (latency 1 clock).
REQ-019 rx_ack with rx_flag set clears rx_flag and rx_overrun next cycle; rx_ack with rx_flag clear has no effect.
REQ-020 Delivery while rx_flag set and no rx_ack same cycle: rx_data overwritten, rx_flag stays 1, rx_overrun set.
REQ-021 Delivery and rx_ack same cycle: new byte wins, rx_flag stays 1, rx_overrun not set (and cleared).
REQ-022 rx_data SHALL be stable while rx_flag=1 unless REQ-020/021 applies.
REQ-023 Tick counter width ceil(log2(DIV)); SHALL not wrap mid-bit; counter reloads on every sample.
REQ-024 rxd activity during a frame SHALL not restart the FSM; only samples matter.

Reset
REQ-025 While ereset_n=0: state IDLE, synchronizer flops 1, counters 0, rx_data=8'h00, rx_flag=0, rx_overrun=0, rx_frame_err=0.
REQ-026 Reset asserted mid-frame SHALL abandon the frame; no partial byte is ever delivered.
REQ-027 After release, a line already low SHALL be treated as a start edge only after the synchronizer has shown 1 then 0.

Structure
REQ-028 Package uart_pkg SHALL hold the FSM state enum and the default CLK_HZ/BAUD constants; shared with the transmitter.
REQ-029 Sub-module sync_2ff (1-bit, reset value parameterized) SHALL implement the synchronizer; nothing else is split out.

Verification (CLK_HZ=160, BAUD=10, DIV=16, HALF=8)
REQ-030 Frame 0x41 (start, 1,0,0,0,0,0,1,0, stop) -> rx_data=0x41, rx_flag=1 one cycle after stop sample; rx_ack pulse -> rx_flag=0 next cycle.
REQ-031 Low pulse of 5 clocks on idle line -> FSM returns to IDLE, rx_flag stays 0, no rx_frame_err.
REQ-032 Frame 0x55 with stop bit held 0 -> rx_frame_err single-cycle pulse, rx_flag 0, no new start until line returns high.
REQ-033 Frames 0x12 then 0x34, no rx_ack -> rx_data=0x34, rx_flag=1, rx_overrun=1; rx_ack clears both.
REQ-034 rx_ack coincident with delivery of 0x34 (0x12 pending) -> rx_data=0x34, rx_flag=1, rx_overrun=0.
REQ-035 ereset_n low during bit 4 of frame 0x7F, then released with line idle -> all outputs at reset values, next clean frame 0x0D received correctly.
